// File: rtl/serial_adder_param.sv
// ============================================================================
//  Module   : serial_adder_param
//  Purpose  : Multi-cycle add/subtract, BITS_PER_CYCLE bits per clock, LSB first
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder_param_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_param #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_slices = WIDTH / BITS_PER_CYCLE;
  localparam int c_cnt_w  = (c_slices > 1) ? $clog2(c_slices) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_slices - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_step;
  logic   w_finish;
  logic   w_last;

  logic [WIDTH-1:0]          r_a;
  logic [WIDTH-1:0]          r_b;
  logic [WIDTH-1:0]          r_acc;
  logic                      r_carry;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [BITS_PER_CYCLE-1:0] w_slice;
  logic [BITS_PER_CYCLE:0]   w_c;
  logic [WIDTH-1:0]          w_acc_nxt;

  assign w_last = (r_cnt == c_last);
  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start is only honoured outside RUN, so operands stay frozen mid-operation
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_c[0] = r_carry;

  generate
    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_cell
      serial_adder_param_fa u_fa (
        .x  (r_a[j]),
        .y  (r_b[j]),
        .ci (w_c[j]),
        .s  (w_slice[j]),
        .co (w_c[j+1])
      );
    end
  endgenerate

  // each new slice enters at the top; after N slices the LSB slice sits at bit 0
  generate
    if (BITS_PER_CYCLE == WIDTH) begin : g_single
      assign w_acc_nxt = w_slice;
    end else begin : g_multi
      assign w_acc_nxt = {w_slice, r_acc[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> BITS_PER_CYCLE;
      r_b     <= r_b >> BITS_PER_CYCLE;
      r_acc   <= w_acc_nxt;
      r_carry <= w_c[BITS_PER_CYCLE];
      r_cnt   <= r_cnt + c_cnt_w'(1);
      if (w_finish) begin
        sum  <= w_acc_nxt;
        cout <= w_c[BITS_PER_CYCLE];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_param.sv
// ============================================================================
//  Module   : tb_serial_adder_param
//  Purpose  : Self-checking bench for serial_adder_param at four geometries
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: 8/1, 1: 8/4, 2: 4/2, 3: 8/8
  logic [3:0]      start_v = '0;
  logic [3:0]      sub_v   = '0;
  logic [3:0]      cin_v   = '0;
  logic [7:0]      a_v [4];
  logic [7:0]      b_v [4];
  wire  [3:0]      busy_v;
  wire  [3:0]      done_v;
  wire  [3:0]      cout_v;
  wire  [3:0][7:0] sum_v;

  int vectors     = 0;
  int miscompares = 0;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = (g == 2) ? 4 : 8;
      localparam int B = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : 8;
      wire [W-1:0] s_loc;
      wire         bz;
      wire         dn;
      wire         co;
      serial_adder_param #(.WIDTH(W), .BITS_PER_CYCLE(B)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start_v[g]),
        .sub   (sub_v[g]),
        .a     (a_v[g][W-1:0]),
        .b     (b_v[g][W-1:0]),
        .cin   (cin_v[g]),
        .busy  (bz),
        .done  (dn),
        .sum   (s_loc),
        .cout  (co)
      );
      assign busy_v[g] = bz;
      assign done_v[g] = dn;
      assign cout_v[g] = co;
      assign sum_v[g]  = 8'(s_loc);
    end
  endgenerate

  function automatic int wof(input int d);
    return (d == 2) ? 4 : 8;
  endfunction

  function automatic int nof(input int d);
    case (d)
      0:       return 8;
      1:       return 2;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // {cout, sum}: plain integer add, or subtract with cout = no borrow
  function automatic logic [8:0] ref_model(input int w, input bit s, input int av,
                                           input int bv, input bit c);
    int m;
    int r;
    logic [8:0] res;
    m = 1 << w;
    if (!s) begin
      r = av + bv + int'(c);
      res[8] = (r >= m);
      r = r % m;
    end else begin
      r = av - bv - int'(c);
      res[8] = (r >= 0);
      r = (r + m) % m;
    end
    res[7:0] = 8'(r);
    return res;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge with the DUT idle or done; returns at the negedge of done.
  task automatic op(input int d, input bit s, input logic [7:0] av, input logic [7:0] bv,
                    input bit c, input logic [8:0] exp, input string tag);
    bit         tim_ok;
    logic [8:0] prev;
    tim_ok = 1'b1;
    prev   = {cout_v[d], sum_v[d]};
    start_v[d] = 1'b1;
    sub_v[d]   = s;
    a_v[d]     = av;
    b_v[d]     = bv;
    cin_v[d]   = c;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int i = 0; i < nof(d); i++) begin
      if (!(busy_v[d] === 1'b1 && done_v[d] === 1'b0)) tim_ok = 1'b0;
      if ({cout_v[d], sum_v[d]} !== prev) tim_ok = 1'b0;
      @(negedge clk);
    end
    check({tag, " handshake"}, {13'd0, tim_ok, busy_v[d], done_v[d]}, 16'b101);
    check({tag, " result"}, {7'd0, cout_v[d], sum_v[d]}, {7'd0, exp});
  endtask

  typedef struct {
    int         d;
    bit         s;
    logic [7:0] a;
    logic [7:0] b;
    bit         c;
    logic [7:0] es;
    bit         ec;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    bit         rs;
    bit         rc;
    int         w;

    tbl[0] = '{0, 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{0, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{0, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{0, 1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1};
    tbl[4] = '{0, 1'b1, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0};
    tbl[5] = '{1, 1'b0, 8'h9C, 8'h67, 1'b1, 8'h04, 1'b1};
    tbl[6] = '{3, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[7] = '{3, 1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0};
    tbl[8] = '{2, 1'b1, 8'h03, 8'h05, 1'b1, 8'h0D, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("reset state dut%0d", i),
            {5'd0, busy_v[i], done_v[i], cout_v[i], sum_v[i]}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // consecutive rows on one instance run back-to-back with start held over done
    foreach (tbl[i])
      op(tbl[i].d, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c, {tbl[i].ec, tbl[i].es},
         $sformatf("table%0d", i));
    @(negedge clk);

    // start pulsed mid-RUN with different operands must be ignored
    start_v[0] = 1'b1; sub_v[0] = 1'b0; a_v[0] = 8'h5A; b_v[0] = 8'h3C; cin_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1; sub_v[0] = 1'b1; a_v[0] = 8'h11; b_v[0] = 8'h22; cin_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun start done", {15'd0, done_v[0]}, 16'd1);
    check("midrun start result", {7'd0, cout_v[0], sum_v[0]}, 16'h0096);
    @(negedge clk);
    check("done single pulse", {14'd0, busy_v[0], done_v[0]}, 16'd0);

    // asynchronous reset in the middle of RUN
    start_v[0] = 1'b1; sub_v[0] = 1'b0; a_v[0] = 8'hA5; b_v[0] = 8'h11; cin_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort dut0", {5'd0, busy_v[0], done_v[0], cout_v[0], sum_v[0]}, 16'd0);
    check("abort dut1", {5'd0, busy_v[1], done_v[1], cout_v[1], sum_v[1]}, 16'd0);
    @(negedge clk);
    check("abort no done", {14'd0, busy_v[0], done_v[0]}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    op(0, 1'b0, 8'hA5, 8'h11, 1'b0, 9'h0B6, "after abort");
    @(negedge clk);

    // exhaustive sweep of the 4-bit, two-slice instance
    for (int m = 0; m < 2; m++)
      for (int ci = 0; ci < 2; ci++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            op(2, m[0], 8'(x), 8'(y), ci[0], ref_model(4, m[0], x, y, ci[0]),
               $sformatf("sweep s%0d c%0d a%0h b%0h", m, ci, x, y));

    // randomized operations, occasionally separated by idle cycles
    for (int k = 0; k < 600; k++) begin
      int d;
      d  = (k % 3 == 2) ? 3 : (k % 3);
      w  = wof(d);
      ra = 8'($urandom_range((1 << w) - 1, 0));
      rb = 8'($urandom_range((1 << w) - 1, 0));
      rs = 1'($urandom_range(1, 0));
      rc = 1'($urandom_range(1, 0));
      op(d, rs, ra, rb, rc, ref_model(w, rs, int'(ra), int'(rb), rc),
         $sformatf("rand%0d dut%0d", k, d));
      if ($urandom_range(3, 0) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
